signed_sat_accumulator: RTL and testbench

Downstream consumer of the 4-bit signed add-with-overflow stage in the 04_PIPE datapath. Accepts a stream of signed samples over a valid/ready handshake. Accumulates each frame of FRAME_LEN samples into a saturating signed accumulator and emits one result per frame over a second valid/ready handshake. The result carries a sticky overflow flag. Overflow detection uses the same sign rule as the upstream adder.

---
 rtl/signed_sat_accumulator.sv | 124 ++++++++++++
 tb/tb_signed_sat_accumulator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_sat_accumulator.sv
// rtl/signed_sat_accumulator.sv - saturating signed frame accumulator with valid/ready in and out
//
// Purpose:
//   Sums each frame of FRAME_LEN signed samples with a saturating adder
//   and emits one result per frame. A sticky flag records whether any
//   add in the frame saturated.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   in_data is valid this cycle
//   in_ready     out  a sample can be accepted this cycle
//   in_data      in   signed sample, WIDTH bits
//   out_valid    out  out_sum/out_overflow hold a completed frame result
//   out_ready    in   consumer takes the result this cycle
//   out_sum      out  signed saturated frame sum, WIDTH bits
//   out_overflow out  set if any add in the frame saturated

module signed_sat_accumulator #(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_overflow
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             live_q;

  logic [WIDTH:0]   wide_sum;
  logic             step_ovf;
  logic [WIDTH-1:0] sat_val;
  logic             accept;

  // Sign-extended add; the extra bit holds the true sign, so a mismatch
  // between the top two bits is exactly the "equal operand signs, result
  // sign differs" overflow rule used upstream.
  assign wide_sum = {acc_q[WIDTH-1], acc_q} + {in_data[WIDTH-1], in_data};
  assign step_ovf = wide_sum[WIDTH] ^ wide_sum[WIDTH-1];
  assign sat_val  = step_ovf ? (wide_sum[WIDTH] ? SAT_MIN : SAT_MAX)
                             : wide_sum[WIDTH-1:0];

  // live_q keeps in_ready low during reset and until the first clock edge
  // after release.
  assign in_ready     = live_q && (state_q == ST_ACCUM);
  assign accept       = in_valid && in_ready;
  assign out_valid    = (state_q == ST_HOLD);
  assign out_sum      = sum_q;
  assign out_overflow = ovf_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;
    if (state_q == ST_ACCUM) begin
      // acc is zero at frame start, so the first sample loads as 0 + x.
      if (accept) begin
        acc_d    = sat_val;
        sticky_d = sticky_q | step_ovf;
        if (cnt_q == LAST_IDX) begin
          sum_d   = sat_val;
          ovf_d   = sticky_q | step_ovf;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else begin
      // out_sum/out_overflow are left untouched so they keep the last
      // result until the next frame completes.
      if (out_ready) begin
        state_d  = ST_ACCUM;
        acc_d    = '0;
        cnt_d    = '0;
        sticky_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ACCUM;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
      live_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// tb/tb_signed_sat_accumulator.sv - self-checking bench for signed_sat_accumulator

module tb_signed_sat_accumulator;

  localparam int WIDTH     = 4;
  localparam int FRAME_LEN = 4;
  localparam int MAXV      = (1 << (WIDTH - 1)) - 1;
  localparam int MINV      = -(1 << (WIDTH - 1));

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef int frame_t [FRAME_LEN];

  signed_sat_accumulator #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: running integer sum clamped to the signed range per step.
  function automatic void model_frame(input frame_t s, output int sum, output bit ovf);
    int acc;
    acc = 0;
    ovf = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      acc = acc + s[i];
      if (acc > MAXV) begin acc = MAXV; ovf = 1'b1; end
      else if (acc < MINV) begin acc = MINV; ovf = 1'b1; end
    end
    sum = acc;
  endfunction

  // Stimulus only: presents one sample and returns at the negedge after it
  // was accepted. waits = negedges spent with in_ready low.
  task automatic push(input int v, output int waits, output bit tmo);
    in_valid = 1'b1;
    in_data  = WIDTH'(v);
    waits    = 0;
    tmo      = 1'b0;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) tmo = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_frame(input frame_t s, output int first_waits, output bit tmo);
    int w;
    bit t;
    tmo = 1'b0;
    first_waits = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      push(s[i], w, t);
      if (i == 0) first_waits = w;
      tmo = tmo | t;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (out_sum !== '0) begin n_fail++; $display("FAIL reset_out_sum got %0d want 0", $signed(out_sum)); end
    if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_out_overflow got %b want 0", out_overflow); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed_frames();
    frame_t tbl [4];
    int esum, w;
    bit eovf, tmo;
    tbl[0] = '{1, 2, -1, 3};
    tbl[1] = '{4, 7, -1, 1};
    tbl[2] = '{-4, -7, 3, -1};
    tbl[3] = '{1, 1, 1, 1};
    out_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      push_frame(tbl[f], w, tmo);
      in_valid = 1'b0;
      model_frame(tbl[f], esum, eovf);
      n_checks += 4;
      if (tmo) begin n_fail++; $display("FAIL directed_timeout frame %0d", f); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL directed_latency frame %0d out_valid %b want 1", f, out_valid); end
      if (out_sum !== WIDTH'(esum)) begin n_fail++; $display("FAIL directed_sum frame %0d got %0d want %0d", f, $signed(out_sum), esum); end
      if (out_overflow !== eovf) begin n_fail++; $display("FAIL directed_ovf frame %0d got %b want %b", f, out_overflow, eovf); end
      @(negedge clk);
      n_checks += 2;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL directed_drop frame %0d out_valid %b want 0", f, out_valid); end
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL directed_ready frame %0d in_ready %b want 1", f, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    frame_t ones, threes;
    int esum, w;
    bit eovf, tmo;
    ones   = '{1, 1, 1, 1};
    threes = '{3, 3, 3, 3};
    out_ready = 1'b0;
    push_frame(ones, w, tmo);
    in_valid = 1'b1;
    in_data  = WIDTH'(3);
    model_frame(ones, esum, eovf);
    for (int c = 0; c < 5; c++) begin
      n_checks += 4;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cycle %0d got %b want 1", c, out_valid); end
      if (out_sum !== WIDTH'(esum)) begin n_fail++; $display("FAIL bp_sum cycle %0d got %0d want %0d", c, $signed(out_sum), esum); end
      if (out_overflow !== eovf) begin n_fail++; $display("FAIL bp_ovf cycle %0d got %b want %b", c, out_overflow, eovf); end
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle %0d got %b want 0", c, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    push_frame(threes, w, tmo);
    in_valid = 1'b0;
    model_frame(threes, esum, eovf);
    n_checks += 4;
    if (tmo) begin n_fail++; $display("FAIL bp_timeout"); end
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_after_valid got %b want 1", out_valid); end
    if (out_sum !== WIDTH'(esum)) begin n_fail++; $display("FAIL bp_after_sum got %0d want %0d", $signed(out_sum), esum); end
    if (out_overflow !== eovf) begin n_fail++; $display("FAIL bp_after_ovf got %b want %b", out_overflow, eovf); end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    frame_t twos, ones;
    int esum, w;
    bit eovf, tmo;
    twos = '{2, 2, 2, 2};
    ones = '{1, 1, 1, 1};
    // Pending, unaccepted result must be dropped by an async reset.
    out_ready = 1'b0;
    push_frame(twos, w, tmo);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_valid got %b want 0", out_valid); end
    if (out_sum !== '0) begin n_fail++; $display("FAIL rst_hold_sum got %0d want 0", $signed(out_sum)); end
    if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_hold_ovf got %b want 0", out_overflow); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_hold_ready got %b want 0", in_ready); end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    // Partial frame discarded.
    push(3, w, tmo);
    push(3, w, tmo);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready got %b want 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(ones, w, tmo);
    in_valid = 1'b0;
    model_frame(ones, esum, eovf);
    n_checks += 4;
    if (tmo) begin n_fail++; $display("FAIL rst_after_timeout"); end
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_after_valid got %b want 1", out_valid); end
    if (out_sum !== WIDTH'(esum)) begin n_fail++; $display("FAIL rst_after_sum got %0d want %0d", $signed(out_sum), esum); end
    if (out_overflow !== eovf) begin n_fail++; $display("FAIL rst_after_ovf got %b want %b", out_overflow, eovf); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    frame_t pat;
    int esum, w;
    bit eovf, tmo;
    time t_prev, t_now;
    pat = '{2, 2, -1, -1};
    out_ready = 1'b1;
    model_frame(pat, esum, eovf);
    t_prev = 0;
    for (int f = 0; f < 3; f++) begin
      push_frame(pat, w, tmo);
      t_now = $time;
      n_checks += 4;
      if (tmo) begin n_fail++; $display("FAIL b2b_timeout frame %0d", f); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid frame %0d got %b want 1", f, out_valid); end
      if (out_sum !== WIDTH'(esum)) begin n_fail++; $display("FAIL b2b_sum frame %0d got %0d want %0d", f, $signed(out_sum), esum); end
      if (out_overflow !== eovf) begin n_fail++; $display("FAIL b2b_ovf frame %0d got %b want %b", f, out_overflow, eovf); end
      if (f > 0) begin
        n_checks += 2;
        if (w != 1) begin n_fail++; $display("FAIL b2b_bubble frame %0d got %0d cycles want 1", f, w); end
        if (t_now - t_prev != 50) begin n_fail++; $display("FAIL b2b_period frame %0d got %0t want 50", f, t_now - t_prev); end
      end
      t_prev = t_now;
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    frame_t s;
    int esum, w, hold;
    bit eovf, tmo;
    for (int f = 0; f < 20; f++) begin
      out_ready = 1'b0;
      for (int i = 0; i < FRAME_LEN; i++) begin
        s[i] = int'($urandom_range(0, 15)) - 8;
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        push(s[i], w, tmo);
        n_checks++;
        if (tmo) begin n_fail++; $display("FAIL rand_timeout frame %0d sample %0d", f, i); end
      end
      in_valid = 1'b0;
      model_frame(s, esum, eovf);
      hold = $urandom_range(0, 3);
      for (int c = 0; c <= hold; c++) begin
        n_checks += 3;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rand_valid frame %0d got %b want 1", f, out_valid); end
        if (out_sum !== WIDTH'(esum)) begin n_fail++; $display("FAIL rand_sum frame %0d got %0d want %0d", f, $signed(out_sum), esum); end
        if (out_overflow !== eovf) begin n_fail++; $display("FAIL rand_ovf frame %0d got %b want %b", f, out_overflow, eovf); end
        if (c == hold) out_ready = 1'b1;
        @(negedge clk);
      end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_drop frame %0d got %b want 0", f, out_valid); end
    end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_directed_frames();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
